clock_reset_sequencer: RTL and testbench

//  Supervises a clock-synthesis PLL from its free-running reference clock: pulses PLL reset, waits for stable lock,

---
 rtl/clkgen_pkg.sv | 20 ++
 rtl/lock_synchronizer.sv | 25 ++
 rtl/clock_reset_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_clock_reset_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// rtl/clkgen_pkg.sv - shared types and constants for the clock/reset sequencer
package clkgen_pkg;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABILIZE,
    ENABLE,
    RUN,
    FAULT
  } clkseq_state_t;

  localparam int LOSS_COUNT_WIDTH = 16;

  // Counter width able to hold max_val without wrapping (never narrower than 1 bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lock_synchronizer.sv
// rtl/lock_synchronizer.sv - two-flop synchroniser for the PLL lock indication
module lock_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta;
  (* ASYNC_REG = "TRUE" *) logic sync;

  // Both stages clear on reset so a stale lock never leaks out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d_async;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/clock_reset_sequencer.sv
// rtl/clock_reset_sequencer.sv - PLL supervisor and staggered domain clock/reset sequencer (option: CLKGEN_LOSS_COUNTER_EN)
module clock_reset_sequencer
  import clkgen_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS         = 3,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned STAGGER_CYCLES      = 8,
  parameter int unsigned MAX_RETRIES         = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  pll_lock_async,
  output logic                                  pll_rst,
  output logic [NUM_DOMAINS-1:0]                clk_en,
  output logic [NUM_DOMAINS-1:0]                domain_rst_n,
  output logic                                  ready,
  output logic                                  fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]      retry_count
`ifdef CLKGEN_LOSS_COUNTER_EN
  ,
  output logic [LOSS_COUNT_WIDTH-1:0]           lock_loss_count
`endif
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam int RST_W   = cnt_width(int'(PLL_RST_CYCLES));
  localparam int TMO_W   = cnt_width(int'(LOCK_TIMEOUT_CYCLES));
  localparam int STAB_W  = cnt_width(int'(LOCK_STABLE_CYCLES));
  localparam int STAG_W  = cnt_width(int'(NUM_DOMAINS * STAGGER_CYCLES));

  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [STAG_W-1:0]  STAG_LAST  = STAG_W'(NUM_DOMAINS * STAGGER_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

  logic lock_s;

  clkseq_state_t state, state_nxt;
  logic [RST_W-1:0]       rst_cnt, rst_cnt_nxt;
  logic [TMO_W-1:0]       tmo_cnt, tmo_cnt_nxt, tmo_inc;
  logic [STAB_W-1:0]      stab_cnt, stab_cnt_nxt;
  logic [STAG_W-1:0]      stag_cnt, stag_cnt_nxt;
  logic [RETRY_W-1:0]     retry_nxt;
  logic                   pll_rst_nxt, ready_nxt, fault_nxt;
  logic [NUM_DOMAINS-1:0] clk_en_nxt, domain_rst_n_nxt;
  logic [31:0]            t_val;

  lock_synchronizer u_lock_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (pll_lock_async),
    .q       (lock_s)
  );

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt        = state;
    rst_cnt_nxt      = rst_cnt;
    tmo_cnt_nxt      = tmo_cnt;
    stab_cnt_nxt     = stab_cnt;
    stag_cnt_nxt     = stag_cnt;
    retry_nxt        = retry_count;
    pll_rst_nxt      = pll_rst;
    clk_en_nxt       = clk_en;
    domain_rst_n_nxt = domain_rst_n;
    ready_nxt        = ready;
    fault_nxt        = fault;
    t_val            = 32'd0;
    // The timeout budget spans WAIT_LOCK and STABILIZE, so a glitchy lock still expires it.
    tmo_inc          = (tmo_cnt == TMO_LAST) ? tmo_cnt : tmo_cnt + 1'b1;

    case (state)
      PLL_RESET: begin
        pll_rst_nxt = 1'b1;
        if (rst_cnt == RST_LAST) begin
          state_nxt   = WAIT_LOCK;
          pll_rst_nxt = 1'b0;
          rst_cnt_nxt = '0;
          tmo_cnt_nxt = '0;
        end else begin
          rst_cnt_nxt = rst_cnt + 1'b1;
        end
      end

      WAIT_LOCK: begin
        if (lock_s) begin
          // Lock beats a coincident timeout.
          state_nxt    = STABILIZE;
          stab_cnt_nxt = '0;
          tmo_cnt_nxt  = tmo_inc;
        end else if (tmo_cnt == TMO_LAST) begin
          pll_rst_nxt = 1'b1;
          if (retry_count == RETRY_LAST) begin
            state_nxt = FAULT;
            fault_nxt = 1'b1;
          end else begin
            state_nxt   = PLL_RESET;
            retry_nxt   = retry_count + 1'b1;
            rst_cnt_nxt = '0;
          end
        end else begin
          tmo_cnt_nxt = tmo_inc;
        end
      end

      STABILIZE: begin
        tmo_cnt_nxt = tmo_inc;
        if (!lock_s) begin
          state_nxt    = WAIT_LOCK;
          stab_cnt_nxt = '0;
        end else if (stab_cnt == STAB_LAST) begin
          state_nxt    = ENABLE;
          stag_cnt_nxt = '0;
        end else begin
          stab_cnt_nxt = stab_cnt + 1'b1;
        end
      end

      ENABLE, RUN: begin
        if (!lock_s) begin
          // Tear every domain down at once; a lost lock is not counted as a retry.
          state_nxt        = PLL_RESET;
          pll_rst_nxt      = 1'b1;
          rst_cnt_nxt      = '0;
          clk_en_nxt       = '0;
          domain_rst_n_nxt = '0;
          ready_nxt        = 1'b0;
        end else if (state == ENABLE) begin
          if (stag_cnt == STAG_LAST) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
            retry_nxt = '0;
          end else begin
            stag_cnt_nxt = stag_cnt + 1'b1;
          end
        end
      end

      FAULT: begin
        pll_rst_nxt      = 1'b1;
        clk_en_nxt       = '0;
        domain_rst_n_nxt = '0;
        ready_nxt        = 1'b0;
        fault_nxt        = 1'b1;
      end

      default: begin
        state_nxt   = PLL_RESET;
        pll_rst_nxt = 1'b1;
        rst_cnt_nxt = '0;
      end
    endcase

    // While enabling, clock enables lead their resets by one stagger slot.
    if (state_nxt == ENABLE) begin
      t_val = 32'(stag_cnt_nxt);
      for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
        clk_en_nxt[i]       = (t_val >= 32'(i) * STAGGER_CYCLES);
        domain_rst_n_nxt[i] = (t_val >= 32'(i + 1) * STAGGER_CYCLES);
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PLL_RESET;
      rst_cnt      <= '0;
      tmo_cnt      <= '0;
      stab_cnt     <= '0;
      stag_cnt     <= '0;
      retry_count  <= '0;
      pll_rst      <= 1'b1;
      clk_en       <= '0;
      domain_rst_n <= '0;
      ready        <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_nxt;
      rst_cnt      <= rst_cnt_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      stab_cnt     <= stab_cnt_nxt;
      stag_cnt     <= stag_cnt_nxt;
      retry_count  <= retry_nxt;
      pll_rst      <= pll_rst_nxt;
      clk_en       <= clk_en_nxt;
      domain_rst_n <= domain_rst_n_nxt;
      ready        <= ready_nxt;
      fault        <= fault_nxt;
    end
  end

`ifdef CLKGEN_LOSS_COUNTER_EN
  logic loss_evt;
  assign loss_evt = ((state == ENABLE) || (state == RUN)) && !lock_s;

  // Saturating count of lock-loss teardowns; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_count <= '0;
    end else if (loss_evt && (lock_loss_count != {LOSS_COUNT_WIDTH{1'b1}})) begin
      lock_loss_count <= lock_loss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// tb/tb_clock_reset_sequencer.sv - directed self-checking bench for clock_reset_sequencer
module tb_clock_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_lock_async;
  logic       pll_rst;
  logic [2:0] clk_en;
  logic [2:0] domain_rst_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
`ifdef CLKGEN_LOSS_COUNTER_EN
  logic [15:0] lock_loss_count;
`endif

  int total = 0;
  int bad   = 0;

  clock_reset_sequencer #(
    .NUM_DOMAINS         (3),
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (16),
    .LOCK_TIMEOUT_CYCLES (64),
    .STAGGER_CYCLES      (2),
    .MAX_RETRIES         (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pll_lock_async (pll_lock_async),
    .pll_rst        (pll_rst),
    .clk_en         (clk_en),
    .domain_rst_n   (domain_rst_n),
    .ready          (ready),
    .fault          (fault),
    .retry_count    (retry_count)
`ifdef CLKGEN_LOSS_COUNTER_EN
    ,
    .lock_loss_count (lock_loss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_clk_en"}, 32'(clk_en), 32'd0);
    chk({tag, "_drst"}, 32'(domain_rst_n), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_retry"}, 32'(retry_count), 32'd0);
`ifdef CLKGEN_LOSS_COUNTER_EN
    chk({tag, "_loss"}, 32'(lock_loss_count), 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    pll_lock_async = 1'b0;
    tick(2);
    chk_reset_vals("rst");

    // Normal bring-up: P0 is the negedge where reset releases.
    rst_n = 1'b1;
    tick(3);
    chk("t1_pllrst_hi", 32'(pll_rst), 32'd1);
    tick(1);
    chk("t1_pllrst_lo", 32'(pll_rst), 32'd0);
    tick(10);
    pll_lock_async = 1'b1;
    tick(18);
    chk("t1_en_pre", 32'(clk_en), 32'd0);
    tick(1);
    chk("t1_en001", 32'(clk_en), 32'b001);
    chk("t1_drst000", 32'(domain_rst_n), 32'b000);
    tick(2);
    chk("t1_en011", 32'(clk_en), 32'b011);
    chk("t1_drst001", 32'(domain_rst_n), 32'b001);
    tick(2);
    chk("t1_en111", 32'(clk_en), 32'b111);
    chk("t1_drst011", 32'(domain_rst_n), 32'b011);
    tick(2);
    chk("t1_drst111", 32'(domain_rst_n), 32'b111);
    chk("t1_ready_pre", 32'(ready), 32'd0);
    tick(1);
    chk("t1_ready", 32'(ready), 32'd1);
    chk("t1_retry", 32'(retry_count), 32'd0);

    // Lock loss in RUN.
    tick(5);
    pll_lock_async = 1'b0;
    tick(2);
    chk("t4_en_hold", 32'(clk_en), 32'b111);
    chk("t4_ready_hold", 32'(ready), 32'd1);
    tick(1);
    chk("t4_en_off", 32'(clk_en), 32'd0);
    chk("t4_drst_off", 32'(domain_rst_n), 32'd0);
    chk("t4_ready_off", 32'(ready), 32'd0);
    chk("t4_pllrst_on", 32'(pll_rst), 32'd1);
`ifdef CLKGEN_LOSS_COUNTER_EN
    chk("t4_loss", 32'(lock_loss_count), 32'd1);
`endif
    tick(3);
    chk("t4_pllrst_4th", 32'(pll_rst), 32'd1);
    tick(1);
    chk("t4_pllrst_off", 32'(pll_rst), 32'd0);
    pll_lock_async = 1'b1;
    tick(19);
    chk("t4_re_en001", 32'(clk_en), 32'b001);
    tick(6);
    chk("t4_re_drst111", 32'(domain_rst_n), 32'b111);
    tick(1);
    chk("t4_re_ready", 32'(ready), 32'd1);
    chk("t4_retry", 32'(retry_count), 32'd0);

    // Glitchy lock in STABILIZE, then lock loss mid-ENABLE.
    rst_n = 1'b0;
    pll_lock_async = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    for (int h = 0; h < 6; h++) begin
      pll_lock_async = ~pll_lock_async;
      tick(10);
    end
    pll_lock_async = 1'b1;
    tick(1);
    chk("t2_pllrst_pre", 32'(pll_rst), 32'd0);
    chk("t2_retry_pre", 32'(retry_count), 32'd0);
    chk("t2_no_enable", 32'(clk_en), 32'd0);
    tick(1);
    chk("t2_pllrst_on", 32'(pll_rst), 32'd1);
    chk("t2_retry1", 32'(retry_count), 32'd1);
    tick(3);
    chk("t2_pllrst_4th", 32'(pll_rst), 32'd1);
    tick(1);
    chk("t2_pllrst_off", 32'(pll_rst), 32'd0);
    tick(17);
    chk("t6_en001", 32'(clk_en), 32'b001);
    tick(3);
    chk("t6_en011_t3", 32'(clk_en), 32'b011);
    pll_lock_async = 1'b0;
    tick(2);
    chk("t6_en111", 32'(clk_en), 32'b111);
    chk("t6_drst011", 32'(domain_rst_n), 32'b011);
    tick(1);
    chk("t6_en_off", 32'(clk_en), 32'd0);
    chk("t6_drst_off", 32'(domain_rst_n), 32'd0);
    chk("t6_pllrst_on", 32'(pll_rst), 32'd1);
    chk("t6_retry_kept", 32'(retry_count), 32'd1);
`ifdef CLKGEN_LOSS_COUNTER_EN
    chk("t6_loss", 32'(lock_loss_count), 32'd1);
`endif
    tick(4);
    chk("t6_pllrst_off", 32'(pll_rst), 32'd0);
    pll_lock_async = 1'b1;
    tick(25);
    chk("t6_ready_pre", 32'(ready), 32'd0);
    chk("t6_retry_pre", 32'(retry_count), 32'd1);
    tick(1);
    chk("t6_ready", 32'(ready), 32'd1);
    chk("t6_retry_clr", 32'(retry_count), 32'd0);

    // Asynchronous reset mid-ENABLE, lock held high throughout.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(23);
    chk("t5_en011", 32'(clk_en), 32'b011);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t5_async");
    @(negedge clk);

    // Lock never arrives: two timeouts then sticky fault.
    pll_lock_async = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(67);
    chk("t3_pllrst_pre", 32'(pll_rst), 32'd0);
    chk("t3_retry0", 32'(retry_count), 32'd0);
    tick(1);
    chk("t3_pllrst_on", 32'(pll_rst), 32'd1);
    chk("t3_retry1", 32'(retry_count), 32'd1);
    tick(4);
    chk("t3_pllrst_off", 32'(pll_rst), 32'd0);
    tick(63);
    chk("t3_fault_pre", 32'(fault), 32'd0);
    tick(1);
    chk("t3_fault", 32'(fault), 32'd1);
    chk("t3_fault_pllrst", 32'(pll_rst), 32'd1);
    chk("t3_fault_en", 32'(clk_en), 32'd0);
    chk("t3_fault_retry", 32'(retry_count), 32'd1);
    pll_lock_async = 1'b1;
    tick(40);
    chk("t3_fault_sticky", 32'(fault), 32'd1);
    chk("t3_sticky_pllrst", 32'(pll_rst), 32'd1);
    chk("t3_sticky_ready", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1 chk("t3_fault_clr", 32'(fault), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
